adder_seq_ctrl: RTL and testbench
=================================

Name: adder_seq_ctrl

Overview:
- Nibble-serial adder sequencer. Adds two NIBBLES*4-bit operands over NIBBLES cycles, using one instance of the team's existing 4-bit slice Adder4bit (ports A, B, CIN, SUM, CARRY).
- The carry from each nibble is registered and fed into the next nibble.
- Sits between the MINI control logic and the shared 4-bit adder, so wide additions run without widening the datapath.
- START/BUSY/DONE handshake toward the issuing logic.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset.
- START  input  1  request pulse or level; sampled only when the block is not BUSY.
- OP_A  input  W  operand A; sampled with START.
- OP_B  input  W  operand B; sampled with START.
- CIN  input  1  carry-in to nibble 0; sampled with START.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle completion strobe.
- RESULT  output  W  sum, LSB nibble first; stable from DONE until the next accepted START.
- COUT  output  1  carry out of the top nibble.

Interface: one clock (CLK); reset (RST) is synchronous and active-high.

Behaviour:
- States: IDLE, RUN, FIN. State is encoded in registers; all outputs are registered.
- Reset:
  - State = IDLE.
  - BUSY=0, DONE=0, RESULT=0, COUT=0.
  - Internal operand shift registers, carry register and nibble counter = 0.
- IDLE, START=1 at edge k:
  - Latch OP_A and OP_B into shift registers SA and SB; carry reg = CIN; counter = 0.
  - Go to RUN; BUSY=1 from edge k.
- RUN, each edge:
  - Slice inputs: A = SA[3:0], B = SB[3:0], CIN = carry reg.
  - RESULT shifts right by 4, with slice SUM inserted at RESULT[W-1:W-4].
  - Carry reg = slice CARRY.
  - SA and SB shift right by 4; counter increments.
- Completion:
  - On the edge where counter == NIBBLES-1 (the NIBBLES-th RUN edge, k+NIBBLES): go to FIN, BUSY=0, DONE=1, COUT = slice CARRY.
  - RESULT holds the full W-bit sum.
- Latency: START sampled at edge k -> DONE high in the cycle after edge k+NIBBLES. Throughput is one operation per NIBBLES+1 cycles.
- FIN, next edge:
  - DONE=0.
  - If START=1: accept a new operation exactly as from IDLE (back-to-back allowed).
  - Else: go to IDLE.
- START while BUSY (RUN): ignored. Operands are not re-sampled and the in-flight operation is unaffected.
- RESULT and COUT:
  - Hold their final value until the first RUN edge of the next operation.
  - RESULT is not valid while BUSY=1; it shows partial shifts.
- RST=1 mid-operation: aborts at that edge, all reset values apply, and no DONE is produced.
- NIBBLES=1 degenerates to a 1-cycle RUN. Latency is then DONE in the cycle after edge k+1.
- Arithmetic is modulo 2^W; the carry out of the top nibble appears only on COUT.

Optional Feature:
- Macro ADDSEQ_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), sampled with START.
  - SUB=1: SB is loaded with ~OP_B and the carry reg with 1 (CIN ignored). RESULT = OP_A - OP_B mod 2^W.
  - COUT=1 means no borrow (OP_A >= OP_B unsigned).
  - SUB=0: behaves exactly as the base block.
- Undefined: no SUB port; addition only.

Test Plan (NIBBLES=4):
- Reset, then START with OP_A=16'hFFFF, OP_B=16'h0001, CIN=0 -> BUSY high for 4 cycles; DONE one cycle after edge k+4; RESULT=16'h0000, COUT=1.
- OP_A=16'h1234, OP_B=16'h4321, CIN=1 -> RESULT=16'h5556, COUT=0; RESULT unchanged 10 cycles after DONE.
- During a RUN of 16'h000F+16'h0001, pulse START with OP_A=16'hAAAA, OP_B=16'h5555 -> ignored; RESULT=16'h0010, COUT=0; no second DONE.
- START held high continuously with 16'h8000+16'h8000, CIN=0 -> DONE every 5 cycles; each RESULT=16'h0000, COUT=1.
- Assert RST for 1 cycle two edges after START -> BUSY=0, DONE=0, RESULT=0, COUT=0; no DONE follows; a subsequent 16'h0002+16'h0003 completes normally with RESULT=16'h0005.
- With ADDSEQ_SUB_EN, SUB=1, OP_A=16'h0005, OP_B=16'h0007 -> RESULT=16'hFFFE, COUT=0. Then OP_A=16'h0007, OP_B=16'h0005 -> RESULT=16'h0002, COUT=1.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: nibble-serial adder sequencer.
// Adds two 4*NIBBLES-bit operands one nibble per cycle through a single
// Adder4bit slice, rippling the carry through a register between nibbles.
// Optional feature macro ADDSEQ_SUB_EN adds a SUB port for A - B.

// Shared 4-bit adder slice.
module Adder4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] SUM,
  output logic       CARRY
);

  // Plain 4-bit add with carry in and carry out.
  assign {CARRY, SUM} = 5'(A) + 5'(B) + 5'(CIN);

endmodule

module adder_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [4*NIBBLES-1:0]   OP_A,
  input  logic [4*NIBBLES-1:0]   OP_B,
  input  logic                   CIN,
`ifdef ADDSEQ_SUB_EN
  input  logic                   SUB,
`endif
  output logic                   BUSY,
  output logic                   DONE,
  output logic [4*NIBBLES-1:0]   RESULT,
  output logic                   COUT
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_sa;
  logic [W-1:0]    r_sb;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;

  logic [3:0]      w_sum;
  logic            w_carry;
  logic [W-1:0]    w_result_next;
  logic [W-1:0]    w_load_b;
  logic            w_load_c;

  // Single shared slice works on the low nibble of the operand shifters.
  Adder4bit u_slice (
    .A     (r_sa[3:0]),
    .B     (r_sb[3:0]),
    .CIN   (r_carry),
    .SUM   (w_sum),
    .CARRY (w_carry)
  );

  // Result fills from the top so the LSB nibble ends up at bit 0 after NIBBLES shifts.
  assign w_result_next = (RESULT >> 4) | (W'(w_sum) << (W - 4));

`ifdef ADDSEQ_SUB_EN
  // Subtract as A + ~B + 1; COUT then reads as "no borrow".
  assign w_load_b = SUB ? ~OP_B : OP_B;
  assign w_load_c = SUB ? 1'b1 : CIN;
`else
  // Addition only.
  assign w_load_b = OP_B;
  assign w_load_c = CIN;
`endif

  // Sequencer FSM with registered handshake and datapath outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= '0;
      COUT    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FIN: begin
          if (START) begin
            r_sa    <= OP_A;
            r_sb    <= w_load_b;
            r_carry <= w_load_c;
            r_cnt   <= '0;
            BUSY    <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          RESULT  <= w_result_next;
          r_carry <= w_carry;
          r_sa    <= r_sa >> 4;
          r_sb    <= r_sb >> 4;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(NIBBLES - 1)) begin
            r_cnt   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            COUT    <= w_carry;
            r_state <= ST_FIN;
          end
        end
        default: begin
          BUSY    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl (NIBBLES=4).
// Honours ADDSEQ_SUB_EN when the design is built with it.
module tb_adder_seq_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 4 * N;
  localparam int unsigned W1 = W + 1;

  logic          CLK;
  logic          RST;
  logic          START;
  logic [W-1:0]  OP_A;
  logic [W-1:0]  OP_B;
  logic          CIN;
`ifdef ADDSEQ_SUB_EN
  logic          SUB;
`endif
  logic          BUSY;
  logic          DONE;
  logic [W-1:0]  RESULT;
  logic          COUT;

  int n_checks = 0;
  int n_fail   = 0;

  adder_seq_ctrl #(.NIBBLES(N)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .OP_A   (OP_A),
    .OP_B   (OP_B),
    .CIN    (CIN),
`ifdef ADDSEQ_SUB_EN
    .SUB    (SUB),
`endif
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT),
    .COUT   (COUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: {carry, sum} of the whole-word operation.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    int unsigned ai;
    int unsigned bi;
    ai = 32'(a);
    bi = 32'(b);
    if (sub) return {(ai >= bi), W'(ai - bi)};
    return W1'(ai + bi + 32'(cin));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_sub(input logic s);
`ifdef ADDSEQ_SUB_EN
    SUB = s;
`else
    if (s) $display("note: SUB requested without ADDSEQ_SUB_EN");
`endif
  endtask

  // One isolated operation with cycle-exact handshake checks.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    logic [W:0] exp;
    exp = model(a, b, cin, sub);
    @(negedge CLK);
    OP_A = a; OP_B = b; CIN = cin; set_sub(sub); START = 1'b1;
    @(posedge CLK); #1;
    chk({tag, " busy@k"}, 32'(BUSY), 32'd1);
    chk({tag, " done@k"}, 32'(DONE), 32'd0);
    @(negedge CLK);
    START = 1'b0;
    OP_A = W'($urandom); OP_B = W'($urandom); CIN = 1'($urandom);
    repeat (N - 1) begin
      @(posedge CLK); #1;
      chk({tag, " busy run"}, 32'(BUSY), 32'd1);
    end
    @(posedge CLK); #1;
    chk({tag, " done"},   32'(DONE),   32'd1);
    chk({tag, " busy0"},  32'(BUSY),   32'd0);
    chk({tag, " result"}, 32'(RESULT), 32'(exp[W-1:0]));
    chk({tag, " cout"},   32'(COUT),   32'(exp[W]));
    @(posedge CLK); #1;
    chk({tag, " done drop"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    int dcount;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;

    RST = 1'b1; START = 1'b0; OP_A = '0; OP_B = '0; CIN = 1'b0;
    set_sub(1'b0);

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst busy",   32'(BUSY),   32'd0);
    chk("rst done",   32'(DONE),   32'd0);
    chk("rst result", 32'(RESULT), 32'd0);
    chk("rst cout",   32'(COUT),   32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Full carry ripple through all nibbles
    run_op("ffff+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("ffff+1 const", 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h10000);

    // Carry-in used and result held while idle
    run_op("1234+4321", 16'h1234, 16'h4321, 1'b1, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    chk("hold result", 32'(RESULT), 32'h5556);
    chk("hold cout",   32'(COUT),   32'd0);
    chk("hold busy",   32'(BUSY),   32'd0);

    // START while busy is ignored
    @(negedge CLK);
    OP_A = 16'h000F; OP_B = 16'h0001; CIN = 1'b0; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    OP_A = 16'hAAAA; OP_B = 16'h5555; CIN = 1'b1; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
    chk("ign done",   32'(DONE),   32'd1);
    chk("ign result", 32'(RESULT), 32'h0010);
    chk("ign cout",   32'(COUT),   32'd0);
    dcount = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) dcount++;
    end
    chk("ign no 2nd op", 32'(dcount), 32'd0);

    // START held: back-to-back operations every N+1 cycles
    @(negedge CLK);
    OP_A = 16'h8000; OP_B = 16'h8000; CIN = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    chk("b2b busy0", 32'(BUSY), 32'd1);
    for (int i = 0; i < 3; i++) begin
      repeat (N - 1) begin
        @(posedge CLK); #1;
        chk("b2b no early done", 32'(DONE), 32'd0);
      end
      @(posedge CLK); #1;
      chk("b2b done",   32'(DONE),   32'd1);
      chk("b2b result", 32'(RESULT), 32'h0000);
      chk("b2b cout",   32'(COUT),   32'd1);
      @(posedge CLK); #1;
      chk("b2b reaccept busy", 32'(BUSY), 32'd1);
      chk("b2b reaccept done", 32'(DONE), 32'd0);
    end
    @(negedge CLK);
    START = 1'b0;
    repeat (N) @(posedge CLK);
    #1;
    chk("b2b last done", 32'(DONE), 32'd1);
    @(posedge CLK); #1;
    chk("b2b idle", 32'(BUSY), 32'd0);

    // Reset mid-operation aborts without DONE
    @(negedge CLK);
    OP_A = 16'h1111; OP_B = 16'h2222; CIN = 1'b0; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort busy",   32'(BUSY),   32'd0);
    chk("abort done",   32'(DONE),   32'd0);
    chk("abort result", 32'(RESULT), 32'd0);
    chk("abort cout",   32'(COUT),   32'd0);
    @(negedge CLK);
    RST = 1'b0;
    dcount = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (DONE) dcount++;
    end
    chk("abort no done", 32'(dcount), 32'd0);
    run_op("2+3", 16'h0002, 16'h0003, 1'b0, 1'b0);

`ifdef ADDSEQ_SUB_EN
    // Subtraction with and without borrow
    run_op("5-7", 16'h0005, 16'h0007, 1'b0, 1'b1);
    run_op("7-5", 16'h0007, 16'h0005, 1'b1, 1'b1);
`endif

    // Randomized operands against the reference
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op("rand", ra, rb, rc, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
